// File: rtl/flappy_scene_engine.sv
// flappy_scene_engine: multi-wall flappy game state, physics, collision, scoring and pixel rasteriser
module flappy_scene_engine #(
  parameter int COORD_W      = 8,
  parameter int SCORE_W      = 8,
  parameter int SCREEN_W     = 160,
  parameter int SCREEN_H     = 120,
  parameter int NUM_WALLS    = 2,
  parameter int WALL_SPACING = 80,
  parameter int BIRD_X       = 20,
  parameter int BIRD_W       = 4,
  parameter int WALL_W       = 10,
  parameter int HOLE_H       = 50,
  parameter int GRAVITY      = 1,
  parameter int FLAP_UP      = 6,
  parameter int WALL_SPEED   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               flap,
  input  logic [COORD_W-1:0] hole_seed,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [2:0]         colour_out,
  output logic               plot,
  output logic               busy,
  output logic               frame_done,
  output logic               collision,
  output logic [SCORE_W-1:0] score_out
);
  localparam int E   = COORD_W + 1;
  localparam int NR  = 2 * NUM_WALLS + 1;
  localparam int R_W = $clog2(NR);
  typedef logic [E-1:0] ext_t;
  typedef logic [COORD_W-1:0] crd_t;
  localparam ext_t BX    = ext_t'(BIRD_X);
  localparam ext_t BXW   = ext_t'(BIRD_X + BIRD_W);
  localparam ext_t BW    = ext_t'(BIRD_W);
  localparam ext_t WW    = ext_t'(WALL_W);
  localparam ext_t HH    = ext_t'(HOLE_H);
  localparam ext_t SH    = ext_t'(SCREEN_H);
  localparam ext_t FU    = ext_t'(FLAP_UP);
  localparam ext_t GR    = ext_t'(GRAVITY);
  localparam ext_t SP    = ext_t'(WALL_SPEED);
  localparam ext_t BMAX  = ext_t'(SCREEN_H - BIRD_W);
  localparam ext_t HMAX  = ext_t'(SCREEN_H - HOLE_H);
  localparam ext_t SPAWN = ext_t'(SCREEN_W - WALL_W);

  typedef enum logic [2:0] {IDLE, ERASE, UPDATE, CHECK, DRAW, DONE} state_t;
  state_t state_q, state_d;
  crd_t bird_q, bird_d;
  crd_t wx_q [NUM_WALLS];
  crd_t wx_d [NUM_WALLS];
  crd_t wh_q [NUM_WALLS];
  crd_t wh_d [NUM_WALLS];
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W:0] sum;
  logic flap_q, flap_d, coll_q, coll_d;
  logic [R_W-1:0] r_q, r_d;
  crd_t px_q, px_d, py_q, py_d;
  crd_t rx, ry, rw, rh;
  logic scanning, empty, x_end, y_end, rect_end, list_end;
  int cnt;

  // state registers; reset restores the opening scene
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bird_q  <= crd_t'((SCREEN_H - BIRD_W) / 2);
      for (int i = 0; i < NUM_WALLS; i++) begin
        wx_q[i] <= crd_t'(SCREEN_W - WALL_W - i * WALL_SPACING);
        wh_q[i] <= crd_t'((SCREEN_H - HOLE_H) / 2);
      end
      score_q <= '0;
      flap_q  <= 1'b0;
      coll_q  <= 1'b0;
      r_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
    end else begin
      state_q <= state_d;
      bird_q  <= bird_d;
      wx_q    <= wx_d;
      wh_q    <= wh_d;
      score_q <= score_d;
      flap_q  <= flap_d;
      coll_q  <= coll_d;
      r_q     <= r_d;
      px_q    <= px_d;
      py_q    <= py_d;
    end
  end

  // geometry of the rectangle currently being walked: 0 = bird, then top/bottom per wall
  always_comb begin
    rx = crd_t'(BIRD_X);
    ry = bird_q;
    rw = crd_t'(BIRD_W);
    rh = crd_t'(BIRD_W);
    for (int i = 0; i < NUM_WALLS; i++) begin
      if (r_q == R_W'(2 * i + 1)) begin
        rx = wx_q[i];
        ry = '0;
        rw = crd_t'(WALL_W);
        rh = wh_q[i];
      end
      if (r_q == R_W'(2 * i + 2)) begin
        rx = wx_q[i];
        ry = crd_t'(ext_t'(wh_q[i]) + HH);
        rw = crd_t'(WALL_W);
        rh = crd_t'(SH - ext_t'(wh_q[i]) - HH);
      end
    end
  end

  assign scanning   = state_q == ERASE || state_q == DRAW;
  assign empty      = rw == '0 || rh == '0;
  assign x_end      = px_q == rw - crd_t'(1);
  assign y_end      = py_q == rh - crd_t'(1);
  assign rect_end   = empty || (x_end && y_end);
  assign list_end   = scanning && rect_end && r_q == R_W'(NR - 1);
  assign plot       = scanning && !empty;
  assign x_out      = plot ? rx + px_q : '0;
  assign y_out      = plot ? ry + py_q : '0;
  assign colour_out = !plot ? 3'b000 : state_q == ERASE ? 3'b111 : r_q == '0 ? 3'b010 : 3'b100;
  assign busy       = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign collision  = coll_q;
  assign score_out  = score_q;

  // raster walk: x inner, y outer, zero-area rectangles skipped in one silent cycle
  always_comb begin
    r_d  = r_q;
    px_d = px_q;
    py_d = py_q;
    if (scanning) begin
      if (rect_end) begin
        px_d = '0;
        py_d = '0;
        r_d  = list_end ? '0 : r_q + R_W'(1);
      end else if (x_end) begin
        px_d = '0;
        py_d = py_q + crd_t'(1);
      end else px_d = px_q + crd_t'(1);
    end
  end

  // frame sequencing; a sticky collision blocks new frames
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = frame_tick && !coll_q ? ERASE : IDLE;
      ERASE:   state_d = list_end ? UPDATE : ERASE;
      UPDATE:  state_d = CHECK;
      CHECK:   state_d = DRAW;
      DRAW:    state_d = list_end ? DONE : DRAW;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // physics and scoring in UPDATE, collision test on the new positions in CHECK
  always_comb begin
    bird_d  = bird_q;
    wx_d    = wx_q;
    wh_d    = wh_q;
    score_d = score_q;
    flap_d  = flap_q | flap;
    coll_d  = coll_q;
    cnt     = 0;
    sum     = '0;
    if (state_q == UPDATE) begin
      flap_d = flap;
      bird_d = flap_q ? (ext_t'(bird_q) < FU ? '0 : bird_q - crd_t'(FLAP_UP))
                      : (ext_t'(bird_q) + GR > BMAX ? crd_t'(BMAX) : bird_q + crd_t'(GRAVITY));
      for (int i = 0; i < NUM_WALLS; i++) begin
        if (ext_t'(wx_q[i]) < SP) begin
          wx_d[i] = crd_t'(SPAWN);
          wh_d[i] = ext_t'(hole_seed) > HMAX ? crd_t'(HMAX) : hole_seed;
        end else begin
          wx_d[i] = wx_q[i] - crd_t'(WALL_SPEED);
          if (ext_t'(wx_q[i]) + WW > BX && ext_t'(wx_q[i]) - SP + WW <= BX) cnt++;
        end
      end
      sum     = {1'b0, score_q} + (SCORE_W + 1)'(cnt);
      score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
    end
    if (state_q == CHECK)
      for (int i = 0; i < NUM_WALLS; i++)
        if (ext_t'(wx_q[i]) < BXW && ext_t'(wx_q[i]) + WW > BX &&
            (ext_t'(bird_q) < ext_t'(wh_q[i]) || ext_t'(bird_q) + BW > ext_t'(wh_q[i]) + HH))
          coll_d = 1'b1;
  end
endmodule
